dmem_req_arbiter: RTL and testbench

Parametrised arbiter between NUM_LD load reservation-station channels, one store channel and the single-ported data cache. It accepts one request at a time through valid/ready handshakes and registers it. It issues the request to the cache as a one-cycle pulse, holds off further grants until `dmem_resp`, and routes the response back to the owning channel. Stores have priority, with a starvation limit that forces a load grant. It replaces the purely combinational store-over-load selector between the LSQ/RS stage and the D-cache.

---
 rtl/dmem_req_arbiter.sv | 163 ++++++++++++++++
 tb/tb_dmem_req_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_arbiter.sv
// dmem_req_arbiter: arbitrates NUM_LD load channels and one store channel
// onto a single-ported data cache, one outstanding request at a time.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_req_valid/addr/rmask  packed per-channel load requests
//   ld_req_ready             one-hot load grant (IDLE only)
//   ld_resp_valid/rdata      one-hot load response strobe + shared data
//   st_req_valid/addr/wdata/wmask, st_req_ready  store request/grant
//   st_resp_valid            store completion strobe
//   dmem_addr/rmask/wmask/wdata  cache request, one-cycle pulse in ISSUE
//   dmem_rdata, dmem_resp    cache response
module dmem_req_arbiter #(
   parameter int NUM_LD       = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_LD-1:0]     ld_req_valid,
   input  logic [NUM_LD*32-1:0]  ld_req_addr,
   input  logic [NUM_LD*4-1:0]   ld_req_rmask,
   output logic [NUM_LD-1:0]     ld_req_ready,
   output logic [NUM_LD-1:0]     ld_resp_valid,
   output logic [31:0]           ld_resp_rdata,
   input  logic                  st_req_valid,
   input  logic [31:0]           st_req_addr,
   input  logic [31:0]           st_req_wdata,
   input  logic [3:0]            st_req_wmask,
   output logic                  st_req_ready,
   output logic                  st_resp_valid,
   output logic [31:0]           dmem_addr,
   output logic [3:0]            dmem_rmask,
   output logic [3:0]            dmem_wmask,
   output logic [31:0]           dmem_wdata,
   input  logic [31:0]           dmem_rdata,
   input  logic                  dmem_resp
);

   localparam int PW = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] rr_nxt;
   logic [PW-1:0] ld_sel;
   logic [CW-1:0] starve_cnt;
   logic [31:0]   sel_addr;
   logic [3:0]    sel_mask;
   logic          ld_found;
   logic          any_ld;
   logic          force_ld;
   logic          st_win;
   logic          st_gnt;
   logic          ld_gnt;
   logic          resp_fire;

   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic [3:0]    req_mask;
   logic          req_st;
   logic [PW-1:0] req_own;

   assign any_ld   = |ld_req_valid;
   assign force_ld = (starve_cnt == CW'(STARVE_LIMIT)) && any_ld;
   assign st_win   = st_req_valid && !force_ld;
   assign st_gnt   = !rst && (state == IDLE) && st_win;
   assign ld_gnt   = !rst && (state == IDLE) && !st_win && ld_found;
   assign resp_fire = !rst && (state == WAIT) && dmem_resp;
   assign rr_nxt   = (ld_sel == PW'(NUM_LD - 1)) ? '0 : ld_sel + 1'b1;

   // Round-robin pick: the valid channel at the smallest rotated
   // distance from rr_ptr wins.
   always_comb begin : rr_search
      int best_d;
      int d;
      best_d   = NUM_LD;
      d        = 0;
      ld_sel   = '0;
      sel_addr = '0;
      sel_mask = '0;
      for (int i = 0; i < NUM_LD; i++) begin
         d = (i + NUM_LD - int'(rr_ptr)) % NUM_LD;
         if (ld_req_valid[i] && d < best_d) begin
            best_d   = d;
            ld_sel   = PW'(i);
            sel_addr = ld_req_addr[32*i +: 32];
            sel_mask = ld_req_rmask[4*i +: 4];
         end
      end
      ld_found = (best_d < NUM_LD);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (st_gnt || ld_gnt) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (dmem_resp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr     <= '0;
         starve_cnt <= '0;
         req_addr   <= '0;
         req_wdata  <= '0;
         req_mask   <= '0;
         req_st     <= 1'b0;
         req_own    <= '0;
      end else if (st_gnt) begin
         if (any_ld && starve_cnt != CW'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 1'b1;
         req_addr  <= {st_req_addr[31:2], 2'b00};
         req_wdata <= st_req_wdata;
         req_mask  <= st_req_wmask;
         req_st    <= 1'b1;
         req_own   <= '0;
      end else if (ld_gnt) begin
         rr_ptr     <= rr_nxt;
         starve_cnt <= '0;
         req_addr   <= {sel_addr[31:2], 2'b00};
         req_wdata  <= '0;
         req_mask   <= sel_mask;
         req_st     <= 1'b0;
         req_own    <= ld_sel;
      end
   end

   always_comb begin
      st_req_ready  = st_gnt;
      st_resp_valid = resp_fire && req_st;
      ld_resp_rdata = (resp_fire && !req_st) ? dmem_rdata : '0;
      for (int i = 0; i < NUM_LD; i++) begin
         ld_req_ready[i]  = ld_gnt && (ld_sel == PW'(i));
         ld_resp_valid[i] = resp_fire && !req_st && (req_own == PW'(i));
      end
      dmem_addr  = '0;
      dmem_rmask = '0;
      dmem_wmask = '0;
      dmem_wdata = '0;
      if (state == ISSUE) begin
         dmem_addr  = req_addr;
         dmem_rmask = req_st ? 4'h0 : req_mask;
         dmem_wmask = req_st ? req_mask : 4'h0;
         dmem_wdata = req_st ? req_wdata : 32'h0;
      end
   end

endmodule

// File: tb/tb_dmem_req_arbiter.sv
// tb_dmem_req_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter.
module tb_dmem_req_arbiter;

   localparam int NL = 2;
   localparam int SL = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    ld_req_valid;
   logic [63:0]   ld_req_addr;
   logic [7:0]    ld_req_rmask;
   logic [1:0]    ld_req_ready;
   logic [1:0]    ld_resp_valid;
   logic [31:0]   ld_resp_rdata;
   logic          st_req_valid;
   logic [31:0]   st_req_addr;
   logic [31:0]   st_req_wdata;
   logic [3:0]    st_req_wmask;
   logic          st_req_ready;
   logic          st_resp_valid;
   logic [31:0]   dmem_addr;
   logic [3:0]    dmem_rmask;
   logic [3:0]    dmem_wmask;
   logic [31:0]   dmem_wdata;
   logic [31:0]   dmem_rdata;
   logic          dmem_resp;

   int checks = 0;
   int passed = 0;

   dmem_req_arbiter #(.NUM_LD(NL), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr),
      .ld_req_rmask(ld_req_rmask), .ld_req_ready(ld_req_ready),
      .ld_resp_valid(ld_resp_valid), .ld_resp_rdata(ld_resp_rdata),
      .st_req_valid(st_req_valid), .st_req_addr(st_req_addr),
      .st_req_wdata(st_req_wdata), .st_req_wmask(st_req_wmask),
      .st_req_ready(st_req_ready), .st_resp_valid(st_resp_valid),
      .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic zero_in;
      ld_req_valid = '0;
      ld_req_addr  = '0;
      ld_req_rmask = '0;
      st_req_valid = 1'b0;
      st_req_addr  = '0;
      st_req_wdata = '0;
      st_req_wmask = '0;
      dmem_rdata   = '0;
      dmem_resp    = 1'b0;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      zero_in();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      zero_in();
      tick();
      #1;
      checks++;
      if ({ld_req_ready, st_req_ready, ld_resp_valid, st_resp_valid} !== 6'b0)
         $display("FAIL reset_strobes: got %b expected 000000",
                  {ld_req_ready, st_req_ready, ld_resp_valid, st_resp_valid});
      else passed++;
      checks++;
      if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, ld_resp_rdata} !== 104'h0)
         $display("FAIL reset_dmem: got %h expected 0",
                  {dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, ld_resp_rdata});
      else passed++;
      checks++;
      if ({dut.rr_ptr, dut.starve_cnt} !== 3'b0)
         $display("FAIL reset_counters: got %b expected 000",
                  {dut.rr_ptr, dut.starve_cnt});
      else passed++;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single_load;
      do_reset();
      ld_req_valid = 2'b10;
      ld_req_addr  = {32'h1000_0006, 32'h0};
      ld_req_rmask = 8'hC0;
      #1;
      checks++;
      if ({ld_req_ready, st_req_ready} !== 3'b100)
         $display("FAIL load_grant: got %b expected 100", {ld_req_ready, st_req_ready});
      else passed++;
      tick();
      ld_req_valid = '0;
      #1;
      checks++;
      if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata} !== {32'h1000_0004, 4'hC, 4'h0, 32'h0})
         $display("FAIL load_issue: got %h/%h/%h/%h expected 10000004/c/0/0",
                  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata);
      else passed++;
      tick();
      #1;
      checks++;
      if ({dmem_addr, dmem_rmask, ld_resp_valid, ld_req_ready} !== 40'h0)
         $display("FAIL load_wait: got %h/%h/%b/%b expected zeros",
                  dmem_addr, dmem_rmask, ld_resp_valid, ld_req_ready);
      else passed++;
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({ld_resp_valid, st_resp_valid, ld_resp_rdata} !== {2'b10, 1'b0, 32'hDEAD_BEEF})
         $display("FAIL load_resp: got %b/%b/%h expected 10/0/deadbeef",
                  ld_resp_valid, st_resp_valid, ld_resp_rdata);
      else passed++;
      tick();
      dmem_resp = 1'b0;
      #1;
      checks++;
      if ({ld_resp_valid, dut.rr_ptr} !== 3'b000)
         $display("FAIL load_after: got %b/%b expected 00/0", ld_resp_valid, dut.rr_ptr);
      else passed++;
   endtask

   task automatic run_grants(input int n, input int exp_seq[6], input string tag);
      int code;
      for (int g = 0; g < n; g++) begin
         #1;
         code = st_req_ready ? 2 : (ld_req_ready == 2'b01) ? 0 :
                (ld_req_ready == 2'b10) ? 1 : 3;
         checks++;
         if (code !== exp_seq[g])
            $display("FAIL %s_grant%0d: got %0d expected %0d", tag, g, code, exp_seq[g]);
         else passed++;
         tick();
         if (exp_seq[g] != 2) begin
            checks++;
            if (dut.starve_cnt !== '0)
               $display("FAIL %s_starve%0d: got %0d expected 0", tag, g, dut.starve_cnt);
            else passed++;
         end
         if (tag == "rr" && g == 1) begin
            checks++;
            if (dut.rr_ptr !== 1'b0)
               $display("FAIL rr_wrap: got %0d expected 0", dut.rr_ptr);
            else passed++;
         end
         tick();
         dmem_resp = 1'b1;
         tick();
         dmem_resp = 1'b0;
      end
   endtask

   task automatic test_starvation;
      int seq[6] = '{2, 2, 0, 2, 2, 1};
      do_reset();
      st_req_valid = 1'b1;
      st_req_addr  = 32'h0000_0100;
      st_req_wmask = 4'h3;
      ld_req_valid = 2'b11;
      ld_req_addr  = {32'h0000_0208, 32'h0000_0204};
      ld_req_rmask = 8'hFF;
      run_grants(6, seq, "starve");
      zero_in();
   endtask

   task automatic test_round_robin;
      int seq[6] = '{0, 1, 0, 0, 0, 0};
      do_reset();
      ld_req_valid = 2'b11;
      ld_req_rmask = 8'h11;
      run_grants(3, seq, "rr");
      zero_in();
   endtask

   task automatic test_store;
      do_reset();
      st_req_valid = 1'b1;
      st_req_addr  = 32'h20;
      st_req_wdata = 32'h1234_5678;
      st_req_wmask = 4'hF;
      #1;
      checks++;
      if ({st_req_ready, ld_req_ready} !== 3'b100)
         $display("FAIL st_grant: got %b expected 100", {st_req_ready, ld_req_ready});
      else passed++;
      tick();
      st_req_valid = 1'b0;
      #1;
      checks++;
      if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata} !== {32'h20, 4'h0, 4'hF, 32'h1234_5678})
         $display("FAIL st_issue: got %h/%h/%h/%h expected 20/0/f/12345678",
                  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata);
      else passed++;
      tick();
      #1;
      checks++;
      if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, st_resp_valid} !== 73'h0)
         $display("FAIL st_wait: got %h/%h/%h/%h/%b expected zeros",
                  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, st_resp_valid);
      else passed++;
      tick();
      dmem_resp = 1'b1;
      #1;
      checks++;
      if ({st_resp_valid, ld_resp_valid} !== 3'b100)
         $display("FAIL st_resp: got %b expected 100", {st_resp_valid, ld_resp_valid});
      else passed++;
      tick();
      dmem_resp = 1'b0;
      #1;
      checks++;
      if (st_resp_valid !== 1'b0)
         $display("FAIL st_resp_once: got %b expected 0", st_resp_valid);
      else passed++;
   endtask

   task automatic test_reset_in_wait;
      do_reset();
      ld_req_valid = 2'b01;
      ld_req_addr  = {32'h0, 32'h0000_0040};
      ld_req_rmask = 8'h0F;
      tick();
      ld_req_valid = 2'b00;
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({ld_resp_valid, st_resp_valid} !== 3'b0)
         $display("FAIL rstw_in_rst: got %b expected 000", {ld_resp_valid, st_resp_valid});
      else passed++;
      tick();
      rst          = 1'b0;
      dmem_resp    = 1'b1;
      dmem_rdata   = 32'hBAD0_BAD0;
      ld_req_valid = 2'b01;
      #1;
      checks++;
      if ({ld_resp_valid, st_resp_valid} !== 3'b0)
         $display("FAIL rstw_late_resp: got %b expected 000", {ld_resp_valid, st_resp_valid});
      else passed++;
      checks++;
      if ({ld_req_ready, st_req_ready} !== 3'b010)
         $display("FAIL rstw_regrant: got %b expected 010", {ld_req_ready, st_req_ready});
      else passed++;
      checks++;
      if ({dut.rr_ptr, dut.starve_cnt} !== 3'b0)
         $display("FAIL rstw_counters: got %b expected 000", {dut.rr_ptr, dut.starve_cnt});
      else passed++;
      tick();
      dmem_resp    = 1'b0;
      ld_req_valid = 2'b00;
      #1;
      checks++;
      if ({dmem_addr, dmem_rmask} !== {32'h40, 4'hF})
         $display("FAIL rstw_issue: got %h/%h expected 40/f", dmem_addr, dmem_rmask);
      else passed++;
      tick();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'h0BAD_F00D;
      #1;
      checks++;
      if ({ld_resp_valid, ld_resp_rdata} !== {2'b01, 32'h0BAD_F00D})
         $display("FAIL rstw_resp: got %b/%h expected 01/0badf00d", ld_resp_valid, ld_resp_rdata);
      else passed++;
      tick();
      dmem_resp = 1'b0;
   endtask

   task automatic test_spurious_resp;
      do_reset();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({ld_resp_valid, st_resp_valid, ld_resp_rdata, dmem_addr, dmem_rmask, dmem_wmask} !== 75'h0)
         $display("FAIL spur_idle: got %b/%b/%h/%h expected zeros",
                  ld_resp_valid, st_resp_valid, ld_resp_rdata, dmem_addr);
      else passed++;
      tick();
      dmem_resp    = 1'b0;
      st_req_valid = 1'b1;
      st_req_wmask = 4'h1;
      #1;
      checks++;
      if (st_req_ready !== 1'b1)
         $display("FAIL spur_still_idle: got %b expected 1", st_req_ready);
      else passed++;
      tick();
      st_req_valid = 1'b0;
      dmem_resp    = 1'b1;
      #1;
      checks++;
      if ({st_resp_valid, ld_resp_valid} !== 3'b0)
         $display("FAIL spur_issue: got %b expected 000", {st_resp_valid, ld_resp_valid});
      else passed++;
      tick();
      #1;
      checks++;
      if (st_resp_valid !== 1'b1)
         $display("FAIL spur_wait_resp: got %b expected 1", st_resp_valid);
      else passed++;
      tick();
      dmem_resp = 1'b0;
   endtask

   // Model: a request accepted at cycle T pulses the cache at T+1 and is
   // answered by the first dmem_resp at T+2 or later; grants only when
   // nothing is outstanding.
   task automatic test_random;
      int m_rr, m_starve, age, nxt, ch;
      logic p_st;
      logic [1:0] p_own;
      logic [31:0] p_addr, p_wdata;
      logic [3:0] p_mask;
      logic [2:0] e_rdy;
      logic [71:0] e_dmem;
      logic [34:0] e_resp;
      do_reset();
      m_rr = 0; m_starve = 0; age = -1;
      p_st = 0; p_own = 0; p_addr = 0; p_wdata = 0; p_mask = 0;
      for (int cyc = 0; cyc < 900; cyc++) begin
         ld_req_valid = 2'($urandom_range(0, 3));
         ld_req_addr  = {$urandom, $urandom};
         ld_req_rmask = 8'($urandom);
         st_req_valid = ($urandom_range(0, 1) == 0);
         st_req_addr  = $urandom;
         st_req_wdata = $urandom;
         st_req_wmask = 4'($urandom);
         dmem_resp    = ($urandom_range(0, 2) == 0);
         dmem_rdata   = $urandom;
         #1;
         e_rdy = '0; e_dmem = '0; e_resp = '0; nxt = age;
         if (age < 0) begin
            if (st_req_valid && !(m_starve == SL && ld_req_valid != 0)) begin
               e_rdy[0] = 1'b1;
               if (ld_req_valid != 0 && m_starve < SL) m_starve++;
               p_st = 1; p_addr = st_req_addr & ~32'h3;
               p_mask = st_req_wmask; p_wdata = st_req_wdata;
               nxt = 1;
            end else if (ld_req_valid != 0) begin
               ch = ld_req_valid[m_rr] ? m_rr : (m_rr + 1) % NL;
               e_rdy[ch + 1] = 1'b1;
               p_st = 0; p_own = 2'(ch);
               p_addr = ld_req_addr[32*ch +: 32] & ~32'h3;
               p_mask = ld_req_rmask[4*ch +: 4];
               m_rr = (ch + 1) % NL;
               m_starve = 0;
               nxt = 1;
            end
         end else if (age == 1) begin
            e_dmem = p_st ? {p_addr, 4'h0, p_mask, p_wdata}
                          : {p_addr, p_mask, 4'h0, 32'h0};
            nxt = 2;
         end else if (dmem_resp) begin
            if (p_st) e_resp[32] = 1'b1;
            else begin
               e_resp[33 + p_own] = 1'b1;
               e_resp[31:0] = dmem_rdata;
            end
            nxt = -1;
         end
         checks++;
         if ({ld_req_ready, st_req_ready} !== e_rdy)
            $display("FAIL rand_ready@%0d: got %b expected %b", cyc,
                     {ld_req_ready, st_req_ready}, e_rdy);
         else passed++;
         checks++;
         if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata} !== e_dmem)
            $display("FAIL rand_dmem@%0d: got %h expected %h", cyc,
                     {dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata}, e_dmem);
         else passed++;
         checks++;
         if ({ld_resp_valid, st_resp_valid, ld_resp_rdata} !== e_resp)
            $display("FAIL rand_resp@%0d: got %h expected %h", cyc,
                     {ld_resp_valid, st_resp_valid, ld_resp_rdata}, e_resp);
         else passed++;
         age = nxt;
         tick();
      end
      zero_in();
   endtask

   initial begin
      rst = 1'b1;
      zero_in();
      #1;
      test_reset();
      test_single_load();
      test_starvation();
      test_round_robin();
      test_store();
      test_reset_in_wait();
      test_spurious_resp();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
